// File: rtl/demux_router_if.sv
// Purpose : bundle of the demux_router producer-side and consumer-side handshake signals.
// Latency : n/a (signal container only).
// Backpressure: in_ready back to the single producer, out_ready[i] from each consumer.
//
// Signals:
//   in_data/in_sel/in_valid/in_ready : single producer stream, in_sel picks channel 0..3 (A..D)
//   out_data/out_valid/out_ready     : four consumer streams, channel i at out_data[i*WIDTH +: WIDTH]
//   in_bcast                         : only with DEMUX_BCAST_EN, pushes one word into all channels
interface demux_router_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0]   in_data;
    logic [1:0]         in_sel;
    logic               in_valid;
    logic               in_ready;
    logic [4*WIDTH-1:0] out_data;
    logic [3:0]         out_valid;
    logic [3:0]         out_ready;
`ifdef DEMUX_BCAST_EN
    logic               in_bcast;

    // master: producer plus consumers (the environment around the router)
    modport master (
        output in_data, in_sel, in_valid, in_bcast, out_ready,
        input  in_ready, out_data, out_valid
    );

    // slave: the router itself
    modport slave (
        input  in_data, in_sel, in_valid, in_bcast, out_ready,
        output in_ready, out_data, out_valid
    );
`else
    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
`endif
endinterface

// File: rtl/demux_router.sv
// Purpose : 1-to-4 stream demultiplexer, 2-entry FIFO per channel, steered by in_sel.
// Latency : word accepted at edge N is visible on its channel right after edge N, poppable at N+1.
// Backpressure: in_ready = selected channel not FULL (no path from out_ready); stalled channel blocks only itself.
//
// Ports:
//   clk, rst_n : single rising-edge clock, asynchronous active-low reset
//   bus        : demux_router_if.slave (producer stream in, four consumer streams out)
// Optional feature macro: DEMUX_BCAST_EN adds bus.in_bcast; when set, one accepted
// word is written into all four channels and in_ready needs every channel not FULL.
module demux_router #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    demux_router_if.slave  bus
);

    typedef enum logic [1:0] {
        CNT_EMPTY = 2'd0,
        CNT_ONE   = 2'd1,
        CNT_FULL  = 2'd2
    } cnt_e;

    // Per-channel state: occupancy, two storage slots, head/tail slot pointers,
    // and the last popped word (shown on out_data while the channel is empty).
    cnt_e                    cnt_q  [4];
    cnt_e                    cnt_d  [4];
    logic [1:0][WIDTH-1:0]   mem_q  [4];
    logic [1:0][WIDTH-1:0]   mem_d  [4];
    logic [WIDTH-1:0]        last_q [4];
    logic [WIDTH-1:0]        last_d [4];
    logic [3:0]              head_q;
    logic [3:0]              head_d;
    logic [3:0]              tail_q;
    logic [3:0]              tail_d;

    logic                    rdy_raw;
    logic                    in_ready_w;
    logic                    accept;
    logic [3:0]              push;
    logic [3:0]              pop;
`ifdef DEMUX_BCAST_EN
    logic                    any_full;
`endif

    // ------------------------------------------------------------------
    // Input acceptance and push steering. in_ready looks only at registered
    // occupancy and in_sel, so a pop in the same cycle never frees a slot
    // for the producer; that keeps out_ready off the in_ready path.
    // ------------------------------------------------------------------
    always_comb begin
        rdy_raw = (cnt_q[bus.in_sel] != CNT_FULL);
`ifdef DEMUX_BCAST_EN
        any_full = 1'b0;
        for (int i = 0; i < 4; i++) begin
            any_full = any_full | (cnt_q[i] == CNT_FULL);
        end
        if (bus.in_bcast) begin
            rdy_raw = ~any_full;
        end
`endif
        // Held low through reset so the producer never sees a phantom accept.
        in_ready_w = rst_n & rdy_raw;
        accept     = bus.in_valid & in_ready_w;
        push       = '0;
        for (int i = 0; i < 4; i++) begin
`ifdef DEMUX_BCAST_EN
            push[i] = accept & (bus.in_bcast | (bus.in_sel == 2'(i)));
`else
            push[i] = accept & (bus.in_sel == 2'(i));
`endif
        end
    end

    assign bus.in_ready = in_ready_w;

    // ------------------------------------------------------------------
    // Per-channel FIFO next state.
    // ------------------------------------------------------------------
    always_comb begin
        pop    = '0;
        head_d = head_q;
        tail_d = tail_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i]  = cnt_q[i];
            mem_d[i]  = mem_q[i];
            last_d[i] = last_q[i];

            pop[i] = (cnt_q[i] != CNT_EMPTY) & bus.out_ready[i];

            if (push[i]) begin
                mem_d[i][tail_q[i]] = bus.in_data;
                tail_d[i]           = ~tail_q[i];
            end
            if (pop[i]) begin
                last_d[i] = mem_q[i][head_q[i]];
                head_d[i] = ~head_q[i];
            end

            // Push and pop together leave the count unchanged; only one of
            // them moves it. Push into FULL cannot happen (in_ready is 0).
            case ({push[i], pop[i]})
                2'b10:   cnt_d[i] = (cnt_q[i] == CNT_EMPTY) ? CNT_ONE : CNT_FULL;
                2'b01:   cnt_d[i] = (cnt_q[i] == CNT_FULL)  ? CNT_ONE : CNT_EMPTY;
                default: cnt_d[i] = cnt_q[i];
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs: head word when occupied, last popped word when empty.
    // ------------------------------------------------------------------
    always_comb begin
        bus.out_valid = '0;
        bus.out_data  = '0;
        for (int i = 0; i < 4; i++) begin
            bus.out_valid[i] = (cnt_q[i] != CNT_EMPTY);
            bus.out_data[i*WIDTH +: WIDTH] = (cnt_q[i] != CNT_EMPTY) ? mem_q[i][head_q[i]]
                                                                      : last_q[i];
        end
    end

    // ------------------------------------------------------------------
    // State registers. Reset discards every buffered word at once.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i]  <= CNT_EMPTY;
                mem_q[i]  <= '0;
                last_q[i] <= '0;
            end
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i]  <= cnt_d[i];
                mem_q[i]  <= mem_d[i];
                last_q[i] <= last_d[i];
            end
        end
    end

endmodule

// File: tb/tb_demux_router.sv
// Purpose : self-checking bench for demux_router against a queue-style reference model.
// Latency : n/a (testbench).
// Backpressure: drives random and directed out_ready stalls; in_ready is predicted by the model.
module tb_demux_router;

    logic clk;
    logic rst_n;

    demux_router_if #(.WIDTH(8)) bus ();

    demux_router #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: each channel is a list of at most two words, slot 0 the
    // oldest. last_pop is what an empty channel shows.
    logic [7:0] mq       [4][2];
    int         mn       [4];
    logic [7:0] last_pop [4];
    logic       bc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            mn[i]       = 0;
            last_pop[i] = 8'h00;
            mq[i][0]    = 8'h00;
            mq[i][1]    = 8'h00;
        end
    endtask

    function automatic logic model_ready();
        logic r;
        r = (mn[bus.in_sel] < 2);
`ifdef DEMUX_BCAST_EN
        if (bc) r = (mn[0] < 2) && (mn[1] < 2) && (mn[2] < 2) && (mn[3] < 2);
`endif
        return r;
    endfunction

    task automatic drive(input logic v, input logic [1:0] s, input logic [7:0] d,
                         input logic [3:0] r);
        bus.in_valid  = v;
        bus.in_sel    = s;
        bus.in_data   = d;
        bus.out_ready = r;
`ifdef DEMUX_BCAST_EN
        bus.in_bcast  = bc;
`endif
        #1;
    endtask

    // Check all outputs against the model, then clock one edge and update it.
    task automatic cycle();
        logic [3:0]  ev;
        logic [31:0] ed;
        logic        er;
        logic [3:0]  pushes;
        logic [3:0]  pops;
        logic [7:0]  d;
        for (int i = 0; i < 4; i++) begin
            ev[i]        = (mn[i] > 0);
            ed[i*8 +: 8] = (mn[i] > 0) ? mq[i][0] : last_pop[i];
        end
        er = model_ready();
        chk("out_valid", {28'd0, bus.out_valid}, {28'd0, ev});
        chk("out_data", bus.out_data, ed);
        chk("in_ready", {31'd0, bus.in_ready}, {31'd0, er});
        d      = bus.in_data;
        pops   = bus.out_ready & ev;
        pushes = '0;
        if (bus.in_valid && er) begin
            if (bc) pushes = 4'hF;
            else    pushes[bus.in_sel] = 1'b1;
        end
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            if (pops[i]) begin
                last_pop[i] = mq[i][0];
                mq[i][0]    = mq[i][1];
                mn[i]--;
            end
            if (pushes[i]) begin
                mq[i][mn[i]] = d;
                mn[i]++;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            drive(1'b0, 2'd0, 8'h00, 4'hF);
            cycle();
        end
    endtask

    initial begin
        bc    = 1'b0;
        rst_n = 1'b0;
        model_clear();
        drive(1'b1, 2'd0, 8'h99, 4'hF);
        @(negedge clk);
        @(negedge clk);

        // Reset state
        chk("rst_out_valid", {28'd0, bus.out_valid}, 32'h0);
        chk("rst_out_data", bus.out_data, 32'h0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'h0);
        drive(1'b0, 2'd0, 8'h00, 4'hF);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'h1);

        // One word to each channel, all consumers ready
        drive(1'b1, 2'd0, 8'h11, 4'hF); cycle();
        chk("a_shows_11", {24'd0, bus.out_data[7:0]}, 32'h11);
        drive(1'b1, 2'd1, 8'h22, 4'hF); cycle();
        drive(1'b1, 2'd2, 8'h33, 4'hF); cycle();
        drive(1'b1, 2'd3, 8'h44, 4'hF); cycle();
        chk("d_shows_44", {24'd0, bus.out_data[31:24]}, 32'h44);
        idle(2);

        // Channel C stalled
        drive(1'b1, 2'd2, 8'hA0, 4'b1011); cycle();
        drive(1'b1, 2'd2, 8'hA1, 4'b1011); cycle();
        drive(1'b1, 2'd2, 8'hA2, 4'b1011);
        chk("c_full_rdy", {31'd0, bus.in_ready}, 32'h0);
        cycle();
        drive(1'b1, 2'd0, 8'h5A, 4'b1011);
        chk("a_while_c_full_rdy", {31'd0, bus.in_ready}, 32'h1);
        cycle();
        drive(1'b0, 2'd0, 8'h00, 4'hF);
        chk("c_head_a0", {24'd0, bus.out_data[23:16]}, 32'hA0);
        cycle();
        chk("c_head_a1", {24'd0, bus.out_data[23:16]}, 32'hA1);
        idle(2);

        // Channel B full with its consumer ready: pop does not open in_ready
        drive(1'b1, 2'd1, 8'hB0, 4'b1101); cycle();
        drive(1'b1, 2'd1, 8'hB1, 4'b1101); cycle();
        drive(1'b1, 2'd1, 8'hB2, 4'hF);
        chk("b_full_pop_rdy", {31'd0, bus.in_ready}, 32'h0);
        cycle();
        drive(1'b1, 2'd1, 8'hB2, 4'hF);
        chk("b_one_rdy", {31'd0, bus.in_ready}, 32'h1);
        cycle();
        idle(3);

        // Channel D: push and pop together in ONE
        drive(1'b1, 2'd3, 8'h55, 4'b0111); cycle();
        drive(1'b1, 2'd3, 8'h66, 4'hF);
        chk("d_head_55", {24'd0, bus.out_data[31:24]}, 32'h55);
        cycle();
        drive(1'b0, 2'd0, 8'h00, 4'b0111);
        chk("d_head_66", {24'd0, bus.out_data[31:24]}, 32'h66);
        chk("d_still_one", {31'd0, bus.out_valid[3]}, 32'h1);
        cycle();
        idle(2);

        // Mid-stream reset with A and B holding words
        drive(1'b1, 2'd0, 8'hC0, 4'h0); cycle();
        drive(1'b1, 2'd1, 8'hC1, 4'h0); cycle();
        drive(1'b1, 2'd0, 8'hC2, 4'h0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {28'd0, bus.out_valid}, 32'h0);
        chk("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'h0);
        chk("mid_rst_out_data", bus.out_data, 32'h0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 2'd0, 8'h00, 4'hF);
        chk("after_rst_in_ready", {31'd0, bus.in_ready}, 32'h1);
        cycle();

`ifdef DEMUX_BCAST_EN
        // Broadcast
        bc = 1'b1;
        drive(1'b1, 2'd1, 8'h7E, 4'h0); cycle();
        chk("bcast_all", bus.out_data, 32'h7E7E7E7E);
        bc = 1'b0;
        drive(1'b1, 2'd2, 8'h01, 4'h0); cycle();
        bc = 1'b1;
        drive(1'b1, 2'd0, 8'h02, 4'h0);
        chk("bcast_one_full_rdy", {31'd0, bus.in_ready}, 32'h0);
        cycle();
        bc = 1'b0;
        idle(3);
`endif

        // Randomized traffic
        for (int k = 0; k < 2500; k++) begin
`ifdef DEMUX_BCAST_EN
            bc = ($urandom_range(0, 7) == 0);
`endif
            drive(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                  8'($urandom), 4'($urandom) | 4'($urandom));
            cycle();
        end
        bc = 1'b0;
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/demux_router.md
# demux_router

Four-way 8-bit stream demultiplexer with per-channel buffering: the steering counterpart of the team's 4:1 output mux. It accepts one word per cycle on a valid/ready input, routes it by a 2-bit select to one of four output channels A–D, and holds each word in a 2-entry per-channel FIFO until that channel's consumer takes it. It sits between a single producer and four independent consumers, so that a stalled consumer only blocks traffic addressed to it.

## Interface
- `WIDTH`, default 8: data width of the input and each output channel.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in_data` input WIDTH: input word.
- `in_sel` input 2: destination channel. 0 = A, 1 = B, 2 = C, 3 = D.
- `in_valid` input 1: producer offers `in_data`/`in_sel`.
- `in_ready` output 1: the selected channel can accept a word.
- `out_data` output 4*WIDTH: channel i head word at bits [i*WIDTH +: WIDTH]. A is slice 0, D is slice 3.
- `out_valid` output 4: channel i FIFO is non-empty.
- `out_ready` input 4: channel i consumer accepts its head word.
- `in_bcast` input 1: present only with `DEMUX_BCAST_EN`; see Configuration.

## Operation
- Channel state is a per-channel occupancy count with three states: EMPTY (0), ONE (1), FULL (2).
- Storage is two entries per channel, with a head pointer and tail pointer that wrap modulo 2.
- Push: a push occurs when `in_valid && in_ready`. The word is written to channel `in_sel` at its tail.
- `in_ready` is the combinational expression (count[in_sel] != FULL).
  - It depends only on registered state and `in_sel`.
  - It has no combinational path from `out_ready`.
- Pop on channel i: a pop occurs when `out_valid[i] && out_ready[i]`. The head pointer advances.
- Transitions per channel:
  - push only: EMPTY→ONE, ONE→FULL.
  - pop only: FULL→ONE, ONE→EMPTY.
  - push and pop in the same cycle: ONE→ONE. The head becomes the newly pushed word on the next cycle.
  - push into FULL: impossible, because `in_ready` is 0. A simultaneous pop on a FULL channel still does not enable a push that cycle.
- Ordering is preserved within each channel. There is no ordering relation across channels.
- `out_data[i]` is undefined-free: it always shows the head entry. When a channel is EMPTY, it holds the last popped value, or 0 after reset.
- `in_data`/`in_sel` are ignored when `in_valid` = 0. A producer holding `in_valid` high may change `in_sel` before acceptance.

## Timing
- Reset values while `rst_n` is low:
  - all counts EMPTY and all pointers 0.
  - `out_valid` = 4'b0000 and `out_data` = 0.
  - `in_ready` forced to 0.
- First cycle after reset release: `in_ready` = 1.
- Latency: a word accepted at edge N appears on `out_valid`/`out_data` of its channel immediately after edge N. It is poppable at edge N+1.
- Throughput: one word per cycle sustained into any one channel while its `out_ready` is held at 1. That channel alternates ONE→ONE.
- Reset asserted mid-operation: all buffered words are discarded immediately and asynchronously. No partial transfer completes.

## Configuration
- `DEMUX_BCAST_EN` defined:
  - The `in_bcast` port exists.
  - When `in_bcast` = 1, `in_sel` is ignored.
  - `in_ready` = all four channels not FULL.
  - An accepted word is pushed into all four channels in the same cycle.
  - When `in_bcast` = 0, behaviour is as without the macro.
- `DEMUX_BCAST_EN` undefined: the `in_bcast` port is absent and only unicast routing exists.

## Test plan
- Reset, then push 0x11 to A, 0x22 to B, 0x33 to C and 0x44 to D, with all `out_ready` = 1 → each `out_valid[i]` pulses for one cycle, carrying 0x11, 0x22, 0x33 and 0x44 respectively, and `in_ready` stays 1.
- Channel C stalled (`out_ready[2]` = 0), push 0xA0, 0xA1, 0xA2 to C → first two accepted; `in_ready` = 0 for 0xA2. A push to A in the same situation is accepted. Raising `out_ready[2]` drains 0xA0 then 0xA1 in order.
- Channel B FULL and `out_ready[1]` = 1, `in_sel` = 1 → `in_ready` = 0 that cycle, and `in_ready` = 1 the next cycle (count ONE).
- Channel D in ONE with 0x55 at head, simultaneous push 0x66 and pop → count stays ONE and the next head is 0x66.
- Fill A and B, then assert `rst_n` = 0 mid-stream → `out_valid` = 0 and `in_ready` = 0 immediately. After release, all channels are EMPTY and `in_ready` = 1.
- With `DEMUX_BCAST_EN`, `in_bcast` = 1, push 0x7E → all four channels present 0x7E. If any one channel is FULL, `in_ready` = 0.
